// File: rtl/md_pkg.sv
// Shared opcodes, cycle defaults and types for the EX-stage multiply/divide unit.
// Also consumed by the hazard unit (md_is_muldiv).
package md_pkg;

    localparam int MD_OP_W        = 3;
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    localparam logic [MD_OP_W-1:0] MD_OP_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_OP_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_OP_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_OP_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_OP_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    typedef struct packed {
        logic [MD_OP_W-1:0] op;
        logic [31:0]        rs;
        logic [31:0]        rt;
    } md_req_t;

    // Multi-cycle ops (MULT/MULTU/DIV/DIVU) occupy the low half of the opcode space.
    function automatic logic md_is_muldiv(input logic [MD_OP_W-1:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/md_unit.sv
// MIPS HI/LO multiply/divide unit; optional pipeline-flush cancel port under MD_CANCEL_EN.
// Latency: MULT/MULTU take MULT_CYCLES, DIV/DIVU take DIV_CYCLES; MTHI/MTLO write on the start edge.
// Backpressure: none internally; busy/md_hazard stall ID, and a start while busy is dropped.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        rs_val,
    input  logic [31:0]        rt_val,
`ifdef MD_CANCEL_EN
    input  logic               cancel,
`endif
    output logic [31:0]        hi,
    output logic [31:0]        lo,
    output logic               busy,
    output logic               md_hazard
);

    md_state_t   state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    md_req_t     req, req_nxt;
    logic [31:0] hi_nxt, lo_nxt;
    logic        flush;

`ifdef MD_CANCEL_EN
    assign flush = cancel;
`else
    assign flush = 1'b0;
`endif

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [32:0] sa, sb, sq, sr;
    logic        [31:0] uq, ur;
    logic               unused_bits;

    assign prod_s = $signed({{32{req.rs[31]}}, req.rs}) * $signed({{32{req.rt[31]}}, req.rt});
    assign prod_u = {32'b0, req.rs} * {32'b0, req.rt};

    // 33-bit signed division keeps 0x80000000 / -1 representable (quotient wraps to 0x80000000).
    assign sa = {req.rs[31], req.rs};
    assign sb = {req.rt[31], req.rt};
    assign sq = sa / sb;
    assign sr = sa % sb;
    assign uq = req.rs / req.rt;
    assign ur = req.rs % req.rt;
    assign unused_bits = ^{sq[32], sr[32]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = req;
        hi_nxt    = hi;
        lo_nxt    = lo;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (md_is_muldiv(md_op)) begin
                        req_nxt   = '{op: md_op, rs: rs_val, rt: rt_val};
                        cnt_nxt   = md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        state_nxt = ST_RUN;
                    end else if (md_op == MD_OP_MTHI) begin
                        hi_nxt = rs_val;
                    end else if (md_op == MD_OP_MTLO) begin
                        lo_nxt = rs_val;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = ST_IDLE;
                        case (req.op)
                            MD_OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
                            MD_OP_MULTU: {hi_nxt, lo_nxt} = prod_u;
                            MD_OP_DIV: if (req.rt != 32'd0) begin
                                hi_nxt = sr[31:0];
                                lo_nxt = sq[31:0];
                            end
                            MD_OP_DIVU: if (req.rt != 32'd0) begin
                                hi_nxt = ur;
                                lo_nxt = uq;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            req   <= '0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            req   <= req_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
    end

    assign busy      = (state == ST_RUN);
    assign md_hazard = start | busy;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the instruction decoded into the ID/EX pipeline register, using forwarded rs/rt values.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- Exposes busy status so the hazard unit can stall MFHI/MFLO and further MD instructions in ID.

Parameters:
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10: busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; EX holds an MD instruction this cycle.
- md_op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-op.
- rs_val  input  32  forwarded rs operand (dividend, multiplicand, or MTHI/MTLO source).
- rt_val  input  32  forwarded rt operand (divisor or multiplier).
- hi  output  32  HI register.
- lo  output  32  LO register.
- busy  output  1  MULT/DIV operation in flight.
- md_hazard  output  1  combinational start|busy; consumed by the hazard unit.

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, latched operands and op cleared. Reset overrides everything, including mid-operation; the in-flight result is discarded.
- State: IDLE (busy=0) and RUN (busy=1). A 4-bit down-counter holds the remaining cycles.
- Accepting a request (IDLE, start=1):
  - md_op 0..3: latch rs_val, rt_val and md_op. Load counter with MULT_CYCLES or DIV_CYCLES. Go to RUN. busy=1 starting the cycle after start.
  - md_op 4: hi<=rs_val on that edge; stay IDLE.
  - md_op 5: lo<=rs_val on that edge; stay IDLE.
  - md_op 6/7: no effect.
- RUN:
  - Decrement the counter each edge.
  - On the edge where counter==1: write hi/lo from the latched operands, busy<=0, return to IDLE.
  - Total: busy is high for exactly N cycles. New hi/lo are visible in the first cycle busy reads 0.
- start while busy=1 is ignored entirely, including MTHI/MTLO. The hazard unit guarantees this never happens; the bench checks it is ignored.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
  - DIVU: unsigned quotient and remainder.
  - Results are computed from the latched operands, not the live inputs.
- Boundaries:
  - Divisor 0: the full busy duration still elapses; hi/lo keep their prior values.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
- Back-to-back: start may be accepted in the same cycle busy falls to 0 (state IDLE). The completing result is written first, then the new operation latches on the next edge.
- md_hazard is purely combinational; hi/lo/busy are registered outputs.

Optional Feature:
- Macro: MD_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit), used for pipeline flush.
  - cancel=1 at an edge while in RUN: return to IDLE, busy<=0, hi/lo unchanged.
  - cancel=1 with start in IDLE: the start is discarded, including MTHI/MTLO.
  - reset has priority over cancel.
- Undefined: no cancel port; an operation always runs to completion.

Decomposition:
- Shared package md_pkg holds:
  - MD_OP_* opcode localparams (3-bit).
  - MD_OP_W=3.
  - Default cycle counts MD_MULT_CYCLES=5 and MD_DIV_CYCLES=10.
  - The md_is_muldiv(op) helper function, reused by the hazard unit.
- No sub-module: control counter and result datapath fit in one module.
- Arithmetic uses the $signed/unsigned operators on the latched 32-bit operands.

Test Plan:
- MULT, rs=0xFFFFFFFE (-2), rt=3, start pulse -> busy high 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV, rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, rs=7, rt=2 -> lo=3, hi=1.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 on consecutive cycles -> hi and lo update on the respective edges; busy stays 0.
- MULT in flight, then start MTLO and start DIV during busy -> both ignored; final hi/lo equal the MULT result only.
- DIV with rt=0 after hi=0xAA, lo=0xBB -> busy 10 cycles; hi=0xAA, lo=0xBB retained. Also DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- reset asserted in cycle 3 of a DIV -> next cycle hi=lo=0 and busy=0; a new MULT 4*5 afterwards yields lo=20, hi=0.
- (MD_CANCEL_EN) cancel in cycle 2 of a MULT -> busy drops next cycle, hi/lo unchanged.
